// File: rtl/fifo_arb_pkg.sv
// Shared types, default parameters and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    // Arbiter states: waiting for a request, or holding a grant.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_N         = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_GAP_MAX   = 8;

    // $clog2 that never returns 0, so a counter or index is always at least 1 bit wide.
    function automatic int safe_clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search: first set request after last_grant, wrapping modulo N.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [$clog2(N)-1:0] pick,
    output logic                 any_valid
);

    localparam int IW = $clog2(N);

    int idx;

    // Walk the N candidates starting one past the previous winner; the first hit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch to hold it.
        pick      = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int step = 1; step <= N; step++) begin
            idx = int'(last_grant) + step;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                pick      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready/last requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int GAP_MAX   = DEF_GAP_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_last,
    input  logic [N*DW-1:0]      req_data,
    output logic [N-1:0]         req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [DW-1:0]        fifo_data,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int BW = safe_clog2(MAX_BURST + 1);
    localparam int GW = safe_clog2(GAP_MAX + 1);

    // Counter values at which a grant is released.
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_MAX - 1);

    arb_state_e    state, state_nxt;
    logic [IW-1:0] last_grant, last_grant_nxt;
    logic [IW-1:0] grant_nxt;
    logic [BW-1:0] beat_cnt, beat_cnt_nxt;
    logic [GW-1:0] gap_cnt, gap_cnt_nxt;

    logic [IW-1:0] pick;
    logic          any_valid;
    logic          cur_valid;
    logic          cur_last;
    logic [DW-1:0] cur_data;
    logic          accept;

    rr_picker #(
        .N (N)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .any_valid  (any_valid)
    );

    // Select the granted requester's handshake lines.
    always_comb begin
        cur_valid = req_valid[grant_id];
        cur_last  = req_last[grant_id];
        cur_data  = req_data[int'(grant_id) * DW +: DW];
    end

    // Accept path and output muxing; reset suppresses every output in its own cycle.
    always_comb begin
        accept     = !rst && (state == ST_GRANT) && cur_valid && !fifo_full;
        busy       = !rst && (state == ST_GRANT);
        fifo_wr_en = accept;
        fifo_data  = accept ? cur_data : '0;
        req_ready  = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Next-state, grant and counter update rules.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_nxt      = grant_id;
        beat_cnt_nxt   = beat_cnt;
        gap_cnt_nxt    = gap_cnt;
        case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    state_nxt      = ST_GRANT;
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    beat_cnt_nxt   = '0;
                    gap_cnt_nxt    = '0;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    if (cur_last || (beat_cnt == BEAT_LAST)) begin
                        state_nxt    = ST_IDLE;
                        beat_cnt_nxt = '0;
                        gap_cnt_nxt  = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + BW'(1);
                        gap_cnt_nxt  = '0;
                    end
                end else if (cur_valid) begin
                    // Stalled on fifo_full: both counters hold.
                    state_nxt = ST_GRANT;
                end else if (gap_cnt == GAP_LAST) begin
                    state_nxt    = ST_IDLE;
                    beat_cnt_nxt = '0;
                    gap_cnt_nxt  = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; last_grant starts at N-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= IW'(N - 1);
            grant_id   <= '0;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_id   <= grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int GAP_MAX   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data;
    logic [1:0]        grant_id;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N         (N),
        .DW        (DW),
        .MAX_BURST (MAX_BURST),
        .GAP_MAX   (GAP_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // ---------------- requester stimulus ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t pkt_q [N][$];
    beat_t pres [N];
    bit    pres_v [N];
    int    bubble [N];
    int    bubble_len [N];   // -1: random gap after each accepted beat
    int    gen_en;
    int    p_present;
    int    p_full;
    int    max_len;
    int    full_left;
    int    cycle = 0;
    logic [DW-1:0] wr_log[$];

    // ---------------- behavioural reference ----------------
    bit m_granted;
    int m_gid;
    int m_last;
    int m_beats;   // beats sent in the current grant
    int m_gap;     // valid-low cycles counted in the current grant
    bit m_acc;

    task automatic gen_packet(input int r);
        int len;
        beat_t b;
        len = $urandom_range(1, max_len);
        for (int k = 0; k < len; k++) begin
            b.data = DW'($urandom);
            b.last = (k == len - 1);
            pkt_q[r].push_back(b);
        end
    endtask

    task automatic drive_inputs();
        for (int r = 0; r < N; r++) begin
            if (pres_v[r] && m_acc && (m_gid == r)) begin
                pres_v[r] = 1'b0;
                if (bubble_len[r] >= 0) bubble[r] = bubble_len[r];
                else if ($urandom_range(0, 9) == 0) bubble[r] = $urandom_range(5, 12);
                else bubble[r] = $urandom_range(0, 2);
            end
            if (!pres_v[r]) begin
                if (bubble[r] > 0) begin
                    bubble[r]--;
                end else begin
                    if (pkt_q[r].size() == 0 && gen_en != 0) gen_packet(r);
                    if (pkt_q[r].size() > 0 && $urandom_range(1, 100) <= p_present) begin
                        pres[r]   = pkt_q[r].pop_front();
                        pres_v[r] = 1'b1;
                    end
                end
            end
            req_valid[r] = pres_v[r];
            req_last[r]  = pres_v[r] ? pres[r].last : 1'($urandom);
            req_data[r*DW +: DW] = pres_v[r] ? pres[r].data : DW'($urandom);
        end
        if (full_left > 0 && m_granted && m_beats == 1) begin
            fifo_full = 1'b1;
            full_left--;
        end else begin
            fifo_full = ($urandom_range(1, 100) <= p_full);
        end
    endtask

    task automatic model_check();
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] exp_data;
        exp_ready = '0;
        exp_data  = '0;
        if (rst) begin
            m_acc = 1'b0;
        end else begin
            m_acc = m_granted && req_valid[m_gid] && !fifo_full;
            if (m_acc) begin
                exp_ready[m_gid] = 1'b1;
                exp_data = req_data[m_gid*DW +: DW];
            end
            check($sformatf("grant_id@%0d", cycle), 64'(grant_id), 64'(m_gid));
        end
        check($sformatf("busy@%0d", cycle), 64'(busy), 64'(!rst && m_granted));
        check($sformatf("req_ready@%0d", cycle), 64'(req_ready), 64'(exp_ready));
        check($sformatf("fifo_wr_en@%0d", cycle), 64'(fifo_wr_en), 64'(m_acc));
        check($sformatf("fifo_data@%0d", cycle), 64'(fifo_data), 64'(exp_data));
        if (fifo_wr_en === 1'b1) wr_log.push_back(fifo_data);
    endtask

    task automatic model_step();
        int c;
        if (rst) begin
            m_granted = 1'b0;
            m_last    = N - 1;
            m_gid     = 0;
            m_beats   = 0;
            m_gap     = 0;
        end else if (!m_granted) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (req_valid[c]) begin
                    m_granted = 1'b1;
                    m_gid     = c;
                    m_last    = c;
                    m_beats   = 0;
                    m_gap     = 0;
                    break;
                end
            end
        end else if (m_acc) begin
            m_beats++;
            m_gap = 0;
            if (req_last[m_gid] || m_beats == MAX_BURST) begin
                m_granted = 1'b0;
                m_beats   = 0;
            end
        end else if (!req_valid[m_gid]) begin
            m_gap++;
            if (m_gap == GAP_MAX) begin
                m_granted = 1'b0;
                m_gap     = 0;
                m_beats   = 0;
            end
        end
    endtask

    task automatic run_cycle(input logic r);
        rst = r;
        drive_inputs();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step();
        cycle++;
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0);
    endtask

    // Clear stimulus state and apply one reset cycle; directed knobs are set afterwards.
    task automatic start_phase();
        for (int r = 0; r < N; r++) begin
            pkt_q[r].delete();
            pres_v[r]     = 1'b0;
            bubble[r]     = 0;
            bubble_len[r] = 0;
        end
        gen_en    = 0;
        p_present = 100;
        p_full    = 0;
        max_len   = 1;
        full_left = 0;
        run_cycle(1'b1);
        wr_log.delete();
    endtask

    task automatic push_beat(input int r, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        pkt_q[r].push_back(b);
    endtask

    task automatic check_log(input string name, input logic [DW-1:0] exp_q[$]);
        check({name, "_count"}, 64'(wr_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_log.size()) check($sformatf("%s_beat%0d", name, i), 64'(wr_log[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        logic [DW-1:0] exp_q[$];
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        m_acc     = 1'b0;
        m_granted = 1'b0;
        m_last    = N - 1;
        m_gid     = 0;
        m_beats   = 0;
        m_gap     = 0;
        @(posedge clk);
        #1;

        // Single requester: req 2 sends A1, A2, A3.
        start_phase();
        push_beat(2, 8'hA1, 1'b0);
        push_beat(2, 8'hA2, 1'b0);
        push_beat(2, 8'hA3, 1'b1);
        run_n(8);
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        check_log("single", exp_q);

        // Fairness: all four requesters continuously valid with one-beat packets.
        start_phase();
        for (int k = 1; k <= 3; k++)
            for (int r = 0; r < N; r++) push_beat(r, DW'(k * 16 + r), 1'b1);
        run_n(30);
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(DW'((i / 4 + 1) * 16 + (i % 4)));
        check_log("fair", exp_q);

        // Burst cap: req 1 sends 8 beats while req 3 waits.
        start_phase();
        for (int k = 1; k <= 8; k++) push_beat(1, DW'(8'h10 + k), (k == 8));
        push_beat(3, 8'h3F, 1'b1);
        run_n(16);
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h3F, 8'h15, 8'h16, 8'h17, 8'h18};
        check_log("burst", exp_q);

        // Full stall: fifo_full for 5 cycles on beat 2 of a 5-beat packet.
        start_phase();
        full_left = 5;
        for (int k = 1; k <= 5; k++) push_beat(0, DW'(8'hC0 + k), (k == 5));
        run_n(16);
        exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        check_log("stall", exp_q);

        // Gap timeout: req 0 goes quiet after beat 1, req 1 waits.
        start_phase();
        bubble_len[0] = 12;
        push_beat(0, 8'hD1, 1'b0);
        push_beat(0, 8'hD2, 1'b1);
        push_beat(1, 8'hE1, 1'b1);
        run_n(30);
        exp_q = '{8'hD1, 8'hE1, 8'hD2};
        check_log("gap", exp_q);

        // Reset mid-burst: the burst is abandoned and requester 0 wins again.
        start_phase();
        push_beat(0, 8'hF1, 1'b0);
        push_beat(0, 8'hF2, 1'b0);
        push_beat(0, 8'hF3, 1'b1);
        push_beat(2, 8'h77, 1'b1);
        run_n(2);
        run_cycle(1'b1);
        run_n(10);
        exp_q = '{8'hF1, 8'hF2, 8'hF3, 8'h77};
        check_log("rst_mid", exp_q);

        // Randomized traffic with random full, gaps and occasional reset.
        start_phase();
        gen_en    = 1;
        p_present = 70;
        p_full    = 20;
        max_len   = 10;
        for (int r = 0; r < N; r++) bubble_len[r] = -1;
        for (int i = 0; i < 3000; i++) run_cycle($urandom_range(0, 299) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
